// File: rtl/hwpe_stream_package.sv
//------------------------------------------------------------------------------
// hwpe_stream_package
// Shared TCDM widths, the per-bank request record and a byte-enable merge.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_TCDM_ADDR_W = 32;
  localparam int unsigned HWPE_STREAM_TCDM_DATA_W = 32;
  localparam int unsigned HWPE_STREAM_TCDM_BE_W   = 4;
  // Widest possible row index: a full word address
  localparam int unsigned HWPE_STREAM_TCDM_ROW_W  = HWPE_STREAM_TCDM_ADDR_W - 2;

  typedef struct packed {
    logic                               wen;
    logic [HWPE_STREAM_TCDM_BE_W-1:0]   be;
    logic [HWPE_STREAM_TCDM_ROW_W-1:0]  row;
    logic [HWPE_STREAM_TCDM_DATA_W-1:0] data;
  } hwpe_stream_tcdm_bank_req_t;

  function automatic logic [HWPE_STREAM_TCDM_DATA_W-1:0] hwpe_stream_tcdm_be_merge(
    input logic [HWPE_STREAM_TCDM_DATA_W-1:0] old_word,
    input logic [HWPE_STREAM_TCDM_DATA_W-1:0] new_word,
    input logic [HWPE_STREAM_TCDM_BE_W-1:0]   be
  );
    logic [HWPE_STREAM_TCDM_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(HWPE_STREAM_TCDM_BE_W); b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_intf_tcdm.sv
//------------------------------------------------------------------------------
// hwpe_stream_intf_tcdm
// TCDM request/response bundle between a master (streamer) and a slave (memory).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hwpe_stream_intf_tcdm;
  import hwpe_stream_package::*;

  logic                               req;
  logic                               gnt;
  logic [HWPE_STREAM_TCDM_ADDR_W-1:0] add;
  logic                               wen;
  logic [HWPE_STREAM_TCDM_BE_W-1:0]   be;
  logic [HWPE_STREAM_TCDM_DATA_W-1:0] data;
  logic [HWPE_STREAM_TCDM_DATA_W-1:0] r_data;
  logic                               r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

`default_nettype wire

// File: rtl/hwpe_stream_tcdm_bank_rr_arb.sv
//------------------------------------------------------------------------------
// hwpe_stream_tcdm_bank_rr_arb
// Per-bank round-robin arbiter: same-cycle one-hot grant, owns the rr pointer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hwpe_stream_tcdm_bank_rr_arb #(
  parameter int unsigned NB_CHAN = 4,
  parameter int unsigned CHAN_IW = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [NB_CHAN-1:0] i_req,
  input  logic               i_stall,
  output logic [NB_CHAN-1:0] o_gnt,
  output logic [CHAN_IW-1:0] o_winner
);

  logic [CHAN_IW-1:0] r_rr_ptr;
  logic [CHAN_IW-1:0] v_idx;
  logic               w_found;

  // First requester at or after the pointer, wrapping in channel order
  always_comb begin
    o_gnt    = '0;
    o_winner = '0;
    w_found  = 1'b0;
    v_idx    = '0;
    for (int unsigned k = 0; k < NB_CHAN; k++) begin
      v_idx = CHAN_IW'((32'(r_rr_ptr) + k) % NB_CHAN);
      if (!w_found && !i_stall && i_req[v_idx]) begin
        w_found      = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_winner     = v_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (32'(o_winner) == NB_CHAN - 1) ? '0 : o_winner + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hwpe_stream_tcdm_responder.sv
//------------------------------------------------------------------------------
// hwpe_stream_tcdm_responder
// Multi-port word-interleaved TCDM memory; optional bank stalls via
// HWPE_STREAM_TCDM_RESPONDER_STALL_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hwpe_stream_tcdm_responder
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_CHAN    = 4,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  hwpe_stream_intf_tcdm.slave tcdm [NB_CHAN]
);

  localparam int unsigned c_BANK_BITS = $clog2(NB_BANKS);
  localparam int unsigned c_BANK_IW   = (NB_BANKS > 1) ? c_BANK_BITS : 1;
  localparam int unsigned c_ROW_W     = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int unsigned c_CHAN_IW   = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

  logic [NB_CHAN-1:0]                 w_req, w_wen, w_gnt;
  logic [NB_CHAN-1:0][31:0]           w_add, w_wdata, w_rdata, w_offs;
  logic [NB_CHAN-1:0][3:0]            w_be;
  logic [NB_CHAN-1:0][c_BANK_IW-1:0]  w_bank;
  logic [NB_CHAN-1:0][c_ROW_W-1:0]    w_row;
  logic [NB_CHAN-1:0]                 w_unused_offs;

  logic [NB_BANKS-1:0][NB_CHAN-1:0]   w_bank_hit, w_bank_gnt;
  logic [NB_BANKS-1:0][c_CHAN_IW-1:0] w_winner;
  logic [NB_BANKS-1:0]                w_bank_vld, w_stall, w_unused_row;
  logic [NB_BANKS-1:0][31:0]          w_bank_rdata;
  hwpe_stream_tcdm_bank_req_t         w_breq [NB_BANKS];

  logic [NB_CHAN-1:0]                 r_valid, r_is_read;
  logic [NB_CHAN-1:0][c_BANK_IW-1:0]  r_bank_sel;

  for (genvar g = 0; g < NB_CHAN; g++) begin : g_chan
    assign w_req[g]          = tcdm[g].req;
    assign w_add[g]          = tcdm[g].add;
    assign w_wen[g]          = tcdm[g].wen;
    assign w_be[g]           = tcdm[g].be;
    assign w_wdata[g]        = tcdm[g].data;
    assign tcdm[g].gnt       = w_gnt[g];
    assign tcdm[g].r_valid   = r_valid[g];
    assign tcdm[g].r_data    = w_rdata[g];
  end

  // Word-interleaved decode; high address bits and add[1:0] fall away
  always_comb begin
    for (int c = 0; c < int'(NB_CHAN); c++) begin
      w_offs[c]        = w_add[c] - BASE_ADDR;
      w_bank[c]        = c_BANK_IW'(w_offs[c][31:2] & 30'(NB_BANKS - 1));
      w_row[c]         = c_ROW_W'((w_offs[c][31:2] >> c_BANK_BITS) & 30'(BANK_WORDS - 1));
      w_unused_offs[c] = ^w_offs[c];
    end
  end

  always_comb begin
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      for (int c = 0; c < int'(NB_CHAN); c++) begin
        w_bank_hit[b][c] = w_req[c] && (w_bank[c] == c_BANK_IW'(b));
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      w_gnt           = w_gnt | w_bank_gnt[b];
      w_bank_vld[b]   = |w_bank_gnt[b];
      w_breq[b].wen   = w_wen[w_winner[b]];
      w_breq[b].be    = w_be[w_winner[b]];
      w_breq[b].row   = HWPE_STREAM_TCDM_ROW_W'(w_row[w_winner[b]]);
      w_breq[b].data  = w_wdata[w_winner[b]];
      w_unused_row[b] = ^w_breq[b].row;
    end
  end

`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
  for (genvar b = 0; b < NB_BANKS; b++) begin : g_lfsr
    logic [15:0] r_lfsr;
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        r_lfsr <= STALL_SEED ^ 16'(b);
      end else begin
        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
    end
    assign w_stall[b] = &r_lfsr[1:0];
  end
`else
  localparam logic [15:0] c_unused_stall_seed = STALL_SEED;
  assign w_stall = '0;
`endif

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [31:0] r_mem [BANK_WORDS];
    logic [31:0] r_rd_word;

    hwpe_stream_tcdm_bank_rr_arb #(
      .NB_CHAN (NB_CHAN),
      .CHAN_IW (c_CHAN_IW)
    ) i_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .i_req    (w_bank_hit[b]),
      .i_stall  (w_stall[b]),
      .o_gnt    (w_bank_gnt[b]),
      .o_winner (w_winner[b])
    );

    // Memory is not reset; a grant commits even while clear_i is high
    always_ff @(posedge clk_i) begin
      if (w_bank_vld[b]) begin
        if (w_breq[b].wen) begin
          r_rd_word <= r_mem[w_breq[b].row[c_ROW_W-1:0]];
        end else begin
          r_mem[w_breq[b].row[c_ROW_W-1:0]] <= hwpe_stream_tcdm_be_merge(
            r_mem[w_breq[b].row[c_ROW_W-1:0]], w_breq[b].data, w_breq[b].be);
        end
      end
    end

    assign w_bank_rdata[b] = r_rd_word;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_valid    <= '0;
      r_is_read  <= '0;
      r_bank_sel <= '0;
    end else begin
      r_valid    <= w_gnt;
      r_is_read  <= w_gnt & w_wen;
      r_bank_sel <= w_bank;
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NB_CHAN); c++) begin
      w_rdata[c] = r_is_read[c] ? w_bank_rdata[r_bank_sel[c]] : 32'h0;
    end
  end

endmodule

`default_nettype wire
